// File: rtl/vga_term_writer.sv
// Text-terminal writer: turns a stream of ASCII bytes into text-RAM cell writes and
// cursor motion, clearing a line on row advance and the whole screen on form feed / reset.
module vga_term_writer #(
  parameter int COLS = 70,
  parameter int ROWS = 30
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam logic [11:0] COLS12      = 12'(COLS);
  localparam logic [11:0] LINE_LAST   = 12'(COLS - 1);
  localparam logic [11:0] SCREEN_LAST = 12'(COLS * ROWS - 1);
  localparam logic [6:0]  LAST_COL    = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW    = 5'(ROWS - 1);

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_LINE,
    CLEAR_SCREEN
  } state_t;

  state_t      state;
  logic [11:0] clr_cnt;
  logic [11:0] row_base;
  logic [11:0] cur_addr;
  logic [4:0]  row_next;
  logic        printable;

  assign row_base  = 12'(cursor_row) * COLS12;
  assign cur_addr  = row_base + 12'(cursor_col);
  assign row_next  = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
  assign printable = (char_data >= CH_SPACE) && (char_data <= CH_TILDE);

  assign char_ready = (state == IDLE);
  assign busy       = ~char_ready;

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR_SCREEN;
      clr_cnt    <= 12'd0;
      wr_en      <= 1'b0;
      wr_addr    <= 12'd0;
      wr_data    <= CH_SPACE;
      cursor_col <= 7'd0;
      cursor_row <= 5'd0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (char_valid) begin
            if (printable) begin
              wr_en   <= 1'b1;
              wr_addr <= cur_addr;
              wr_data <= char_data;
              if (cursor_col == LAST_COL) begin
                cursor_col <= 7'd0;
                cursor_row <= row_next;
                clr_cnt    <= 12'd0;
                state      <= CLEAR_LINE;
              end else begin
                cursor_col <= cursor_col + 7'd1;
              end
            end else begin
              case (char_data)
                CH_LF: begin
                  cursor_col <= 7'd0;
                  cursor_row <= row_next;
                  clr_cnt    <= 12'd0;
                  state      <= CLEAR_LINE;
                end
                CH_CR: cursor_col <= 7'd0;
                CH_BS: begin
                  // The cell left of the cursor is always cur_addr-1, even across a row edge.
                  if (cursor_col != 7'd0) begin
                    cursor_col <= cursor_col - 7'd1;
                    wr_en      <= 1'b1;
                    wr_addr    <= cur_addr - 12'd1;
                    wr_data    <= CH_SPACE;
                  end else if (cursor_row != 5'd0) begin
                    cursor_col <= LAST_COL;
                    cursor_row <= cursor_row - 5'd1;
                    wr_en      <= 1'b1;
                    wr_addr    <= cur_addr - 12'd1;
                    wr_data    <= CH_SPACE;
                  end
                end
                CH_FF: begin
                  cursor_col <= 7'd0;
                  cursor_row <= 5'd0;
                  clr_cnt    <= 12'd0;
                  state      <= CLEAR_SCREEN;
                end
                default: ;
              endcase
            end
          end
        end
        CLEAR_LINE: begin
          wr_en   <= 1'b1;
          wr_addr <= row_base + clr_cnt;
          wr_data <= CH_SPACE;
          if (clr_cnt == LINE_LAST) begin
            clr_cnt <= 12'd0;
            state   <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + 12'd1;
          end
        end
        CLEAR_SCREEN: begin
          wr_en   <= 1'b1;
          wr_addr <= clr_cnt;
          wr_data <= CH_SPACE;
          if (clr_cnt == SCREEN_LAST) begin
            clr_cnt <= 12'd0;
            state   <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_term_writer.sv
// Directed bench for vga_term_writer: screen clear, typing, wrap, LF/BS/CR/FF and reset abort.
module tb_vga_term_writer;

  logic        vga_clk = 1'b0;
  logic        rst;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int checks = 0;
  int errors = 0;

  vga_term_writer dut (
    .vga_clk    (vga_clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wr_vec(input logic en, input int addr, input logic [7:0] d);
    return {11'd0, en, 12'(addr), d};
  endfunction

  function automatic logic [31:0] cur_vec(input int col, input int row);
    return {20'd0, 7'(col), 5'(row)};
  endfunction

  // Called at a falling edge; the byte is presented across exactly one rising edge.
  task automatic send(input logic [7:0] b);
    char_valid = 1'b1;
    char_data  = b;
    @(negedge vga_clk);
    char_valid = 1'b0;
  endtask

  task automatic wait_ready(input int max_cycles);
    for (int i = 0; i < max_cycles && !char_ready; i++) @(negedge vga_clk);
    chk("ready_timeout", {31'd0, char_ready}, 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    repeat (3) @(negedge vga_clk);

    chk("rst_wr",    wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b0, 0, 8'h20));
    chk("rst_cur",   {cursor_col, cursor_row}, cur_vec(0, 0));
    chk("rst_rdy",   {char_ready, busy}, 32'b01);

    // Power-up clear of the whole screen
    rst = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge vga_clk);
      chk("scr_wr", wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b1, i, 8'h20));
      chk("scr_rdy", {char_ready, busy}, (i == 2099) ? 32'b10 : 32'b01);
    end
    @(negedge vga_clk);
    chk("scr_done_wr",  {31'd0, wr_en}, 32'd0);
    chk("scr_done_rdy", {char_ready, busy}, 32'b10);
    chk("scr_done_cur", {cursor_col, cursor_row}, cur_vec(0, 0));

    // Back-to-back printable bytes
    char_valid = 1'b1;
    char_data  = 8'h41;
    @(negedge vga_clk);
    chk("ab_a",   wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b1, 0, 8'h41));
    chk("ab_rdy", {31'd0, char_ready}, 32'd1);
    char_data  = 8'h42;
    @(negedge vga_clk);
    char_valid = 1'b0;
    chk("ab_b",   wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b1, 1, 8'h42));
    chk("ab_cur", {cursor_col, cursor_row}, cur_vec(2, 0));
    @(negedge vga_clk);
    chk("ab_idle", {wr_en, char_ready}, 32'b01);

    // Fill to column 69, then wrap onto row 1
    char_valid = 1'b1;
    for (int c = 2; c < 69; c++) begin
      char_data = 8'h61 + 8'(c % 26);
      @(negedge vga_clk);
    end
    char_valid = 1'b0;
    chk("fill_wr",  wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b1, 68, 8'h61 + 8'(68 % 26)));
    chk("fill_cur", {cursor_col, cursor_row}, cur_vec(69, 0));
    send(8'h5A);
    chk("wrap_wr",  wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b1, 69, 8'h5A));
    chk("wrap_cur", {cursor_col, cursor_row}, cur_vec(0, 1));
    chk("wrap_rdy", {31'd0, char_ready}, 32'd0);
    for (int i = 0; i < 70; i++) begin
      @(negedge vga_clk);
      chk("line1_wr",  wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b1, 70 + i, 8'h20));
      chk("line1_rdy", {31'd0, char_ready}, (i == 69) ? 32'd1 : 32'd0);
    end
    @(negedge vga_clk);
    chk("line1_end", {wr_en, char_ready}, 32'b01);

    // Backspace across the row edge, mid-row, at origin, and an ignored control
    send(8'h08);
    chk("bs_edge_wr",  wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b1, 69, 8'h20));
    chk("bs_edge_cur", {cursor_col, cursor_row}, cur_vec(69, 0));
    send(8'h0D);
    chk("cr_wr",  {31'd0, wr_en}, 32'd0);
    chk("cr_cur", {cursor_col, cursor_row}, cur_vec(0, 0));
    send(8'h51);
    chk("q_wr", wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b1, 0, 8'h51));
    send(8'h08);
    chk("bs_mid_wr",  wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b1, 0, 8'h20));
    chk("bs_mid_cur", {cursor_col, cursor_row}, cur_vec(0, 0));
    send(8'h08);
    chk("bs_org_wr",  {31'd0, wr_en}, 32'd0);
    chk("bs_org_cur", {cursor_col, cursor_row}, cur_vec(0, 0));
    send(8'h07);
    chk("bel_wr",  {31'd0, wr_en}, 32'd0);
    chk("bel_cur", {cursor_col, cursor_row}, cur_vec(0, 0));
    send(8'hC5);
    chk("hi_wr",  {wr_en, char_ready}, 32'b01);
    chk("hi_cur", {cursor_col, cursor_row}, cur_vec(0, 0));

    // Walk down to row 29 with LFs, then LF wraps to row 0 and clears it
    for (int r = 1; r < 30; r++) begin
      send(8'h0A);
      wait_ready(100);
    end
    @(negedge vga_clk);
    chk("lf29_cur", {cursor_col, cursor_row}, cur_vec(0, 29));
    send(8'h0A);
    chk("lfw_wr",  {31'd0, wr_en}, 32'd0);
    chk("lfw_cur", {cursor_col, cursor_row}, cur_vec(0, 0));
    chk("lfw_rdy", {char_ready, busy}, 32'b01);
    for (int i = 0; i < 70; i++) begin
      @(negedge vga_clk);
      chk("line0_wr", wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b1, i, 8'h20));
    end
    @(negedge vga_clk);
    chk("line0_end", {wr_en, char_ready}, 32'b01);

    // Form feed from a non-origin cursor, then reset in the middle of the clear
    send(8'h48);
    send(8'h0C);
    chk("ff_wr",  {31'd0, wr_en}, 32'd0);
    chk("ff_cur", {cursor_col, cursor_row}, cur_vec(0, 0));
    chk("ff_rdy", {char_ready, busy}, 32'b01);
    @(negedge vga_clk);
    chk("ff_first", wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b1, 0, 8'h20));
    for (int i = 0; i < 1500 && !(wr_en && wr_addr == 12'd1000); i++) @(negedge vga_clk);
    chk("ff_at1000", wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b1, 1000, 8'h20));
    rst = 1'b1;
    #1;
    chk("abort_wr",  wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b0, 0, 8'h20));
    chk("abort_rdy", {char_ready, busy}, 32'b01);
    @(negedge vga_clk);
    chk("abort_hold", {31'd0, wr_en}, 32'd0);
    rst = 1'b0;
    @(negedge vga_clk);
    chk("restart0", wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b1, 0, 8'h20));
    @(negedge vga_clk);
    chk("restart1", wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b1, 1, 8'h20));
    wait_ready(2200);
    chk("restart_last", wr_vec(wr_en, wr_addr, wr_data), wr_vec(1'b1, 2099, 8'h20));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
